// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and default sizes for the data-RAM arbiter.
//   state_e  : arbiter FSM states
//   master_e : identity of the master that owns the current transaction
package dmem_arb_pkg;

  localparam int unsigned DefAddrW = 12;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  typedef enum logic {
    M_CPU,
    M_DBG
  } master_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner selection between the CPU and debug masters.
// Ports:
//   cpu_req     in  CPU is requesting
//   dbg_req     in  debug master is requesting
//   force_dbg   in  starvation guard demands a debug grant
//   grant_valid out at least one master is requesting
//   grant_id    out winning master (CPU unless debug alone or forced)
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic    cpu_req,
  input  logic    dbg_req,
  input  logic    force_dbg,
  output logic    grant_valid,
  output master_e grant_id
);

  always_comb begin
    grant_valid = cpu_req | dbg_req;
    grant_id    = M_CPU;
    if (dbg_req && (!cpu_req || force_dbg)) begin
      grant_id = M_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous single-port data RAM between the CPU data port
// and a debug/loader master. Each access takes three cycles: IDLE (arbitrate and latch),
// ACCESS (drive the RAM), RESP (one-cycle ready pulse with read data).
// Ports:
//   clock, reset                    clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata           CPU request, held until cpu_ready
//   cpu_ready, cpu_rdata            CPU completion pulse and read data
//   dbg_req/we/addr/wdata           debug request, held until dbg_ready
//   dbg_ready, dbg_rdata            debug completion pulse and read data
//   ram_wEn, ram_addr, ram_dataIn   RAM controls (address/data hold their latched values)
//   ram_dataOut                     RAM read data, one cycle after address
// Configuration: define DMEM_ARB_STARVE_GUARD_EN to build the starvation guard, which
// forces a debug grant after MAX_CPU_BURST consecutive CPU grants while debug waits.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = DefAddrW,
  parameter int unsigned DATA_W        = DefDataW,
  parameter int unsigned MAX_CPU_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  if (MAX_CPU_BURST < 1 || MAX_CPU_BURST > 15) begin : g_burst_range
    $error("MAX_CPU_BURST must be in 1..15");
  end

  state_e            state_q, state_d;
  master_e           winner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic    grant_valid;
  master_e grant_id;
  logic    force_dbg;
  logic    latch_en;

  dmem_arb_pick u_pick (
    .cpu_req     (cpu_req),
    .dbg_req     (dbg_req),
    .force_dbg   (force_dbg),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Requests are only looked at in IDLE; RESP never arbitrates, so a served master
  // still holding req cannot be granted twice.
  assign latch_en = (state_q == ST_IDLE) && grant_valid;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] MaxBurst = 4'(MAX_CPU_BURST);

  logic [3:0] burst_q, burst_d;

  always_comb begin
    burst_d = burst_q;
    if (state_q == ST_IDLE) begin
      if (!dbg_req) begin
        burst_d = '0;
      end else if (grant_valid) begin
        if (grant_id == M_DBG) begin
          burst_d = '0;
        end else begin
          burst_d = burst_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end

  assign force_dbg = (burst_q == MaxBurst);
`else
  assign force_dbg = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (grant_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      winner_q <= M_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        winner_q <= grant_id;
        if (grant_id == M_DBG) begin
          we_q    <= dbg_we;
          addr_q  <= dbg_addr;
          wdata_q <= dbg_wdata;
        end else begin
          we_q    <= cpu_we;
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
        end
      end
    end
  end

  // Address and write data hold the last latched request; only the enable is gated.
  assign ram_addr   = addr_q;
  assign ram_dataIn = wdata_q;
  assign ram_wEn    = (state_q == ST_ACCESS) && we_q;

  assign cpu_ready = (state_q == ST_RESP) && (winner_q == M_CPU);
  assign dbg_ready = (state_q == ST_RESP) && (winner_q == M_DBG);

  assign cpu_rdata = (cpu_ready && !we_q) ? ram_dataOut : '0;
  assign dbg_rdata = (dbg_ready && !we_q) ? ram_dataOut : '0;

endmodule
